// File: rtl/mips32_reg_dump_if.sv
// mips32_reg_dump_if: valid/ready word stream carrying the register-file dump.
// The dump engine drives through master; the host/scoreboard/UART bridge uses slave.
interface mips32_reg_dump_if #(
    parameter int DW = 32
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mips32_reg_dump.sv
// mips32_reg_dump: after the core halts, walks r0..r(NREGS-1) and streams each word out.
// Define MIPS32_DUMP_HDR_EN to prepend a header word {8'hA5, NREGS, pc[15:0]}.
module mips32_reg_dump #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              halted,
    input  logic              dump_req,
    input  logic [31:0]       pc,
    output logic [AW-1:0]     rf_addr,
    input  logic [DW-1:0]     rf_rdata,
    mips32_reg_dump_if.master dump,
    output logic              busy,
    output logic              done
);

`ifdef MIPS32_DUMP_HDR_EN
    typedef enum logic [2:0] {IDLE, HDR, RD, SEND, DONE} state_t;

    logic [DW-1:0] hdr_word;
    assign hdr_word = DW'({8'hA5, 8'(NREGS), pc[15:0]});
`else
    typedef enum logic [1:0] {IDLE, RD, SEND, DONE} state_t;

    // Without the header the PC is not needed.
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic          halted_q;
    logic          trig;
    logic          hs;

    // A level-held halt must only start one dump, so only its rising edge counts.
    assign trig = (halted & ~halted_q) | dump_req;
    assign hs   = dump.out_valid & dump.out_ready;

    // NOTE: every state bit and registered output lives in this one clocked block and
    // is written with <=, so all branches see the pre-edge values of idx/out_last.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            halted_q       <= 1'b0;
            rf_addr        <= '0;
            dump.out_valid <= 1'b0;
            dump.out_data  <= '0;
            dump.out_last  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            halted_q <= halted;
            case (state)
                IDLE, DONE: begin
                    if (trig) begin
                        idx     <= '0;
                        rf_addr <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
`ifdef MIPS32_DUMP_HDR_EN
                        dump.out_data  <= hdr_word;
                        dump.out_valid <= 1'b1;
                        dump.out_last  <= 1'b0;
                        state          <= HDR;
`else
                        state   <= RD;
`endif
                    end
                end
`ifdef MIPS32_DUMP_HDR_EN
                HDR: begin
                    if (hs) begin
                        dump.out_valid <= 1'b0;
                        rf_addr        <= '0;
                        state          <= RD;
                    end
                end
`endif
                RD: begin
                    // The read port is combinational; rf_addr was set on the previous edge.
                    dump.out_data  <= rf_rdata;
                    dump.out_valid <= 1'b1;
                    dump.out_last  <= (idx == LAST_IDX);
                    state          <= SEND;
                end
                SEND: begin
                    if (hs) begin
                        dump.out_valid <= 1'b0;
                        if (dump.out_last) begin
                            dump.out_last <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= DONE;
                        end else begin
                            idx     <= idx + 1'b1;
                            rf_addr <= idx + 1'b1;
                            state   <= RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_reg_dump.sv
// tb_mips32_reg_dump: directed + randomized checks of the register dump stream against
// a word-list model built from the register file contents at each trigger.
module tb_mips32_reg_dump;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
`ifdef MIPS32_DUMP_HDR_EN
    localparam int HOFF = 1;
`else
    localparam int HOFF = 0;
`endif

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          halted;
    logic          dump_req;
    logic [31:0]   pc;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_rdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] regfile [NREGS];

    mips32_reg_dump_if #(.DW(DW)) dump_if ();

    mips32_reg_dump #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .halted   (halted),
        .dump_req (dump_req),
        .pc       (pc),
        .rf_addr  (rf_addr),
        .rf_rdata (rf_rdata),
        .dump     (dump_if),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk1 = ~clk1;

    assign rf_rdata = regfile[rf_addr];

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [DW-1:0] rx_data [$];
    logic          rx_last [$];
    int            rx_cyc  [$];
    logic [DW-1:0] exp_data[$];

    // Records every accepted word together with the index of the edge that accepted it.
    always @(posedge clk1) begin
        if (rst_n === 1'b1 && dump_if.out_valid === 1'b1 && dump_if.out_ready === 1'b1) begin
            rx_data.push_back(dump_if.out_data);
            rx_last.push_back(dump_if.out_last);
            rx_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
    endtask

    // Expected stream: optional header, then every register as it stands at the trigger.
    task automatic build_expected();
        exp_data.delete();
`ifdef MIPS32_DUMP_HDR_EN
        exp_data.push_back(32'hA500_0000 + (NREGS << 16) + {16'h0, pc[15:0]});
`endif
        for (int i = 0; i < NREGS; i++) exp_data.push_back(regfile[i]);
    endtask

    // Raises halted and/or pulses dump_req for one edge; t0 is that edge's index.
    task automatic fire(input bit h, input bit r, output int t0);
        @(negedge clk1);
        if (h) halted = 1'b1;
        dump_req = r;
        t0 = cyc;
        build_expected();
        @(negedge clk1);
        dump_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1 && busy === 1'b0) break;
            @(negedge clk1);
        end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_valid(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dump_if.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk1);
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic compare_dump(input string tag);
        int n;
        check({tag, "_count"}, rx_data.size(), exp_data.size());
        n = (rx_data.size() < exp_data.size()) ? rx_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), rx_data[i], exp_data[i]);
            check($sformatf("%s_last%0d", tag, i), rx_last[i], (i == exp_data.size() - 1));
        end
    endtask

    // Only meaningful with out_ready held high for the whole dump.
    task automatic check_timing(input string tag, input int t0);
        if (rx_cyc.size() == 0) begin
            check({tag, "_no_words"}, rx_cyc.size(), exp_data.size());
        end else begin
            check({tag, "_first_cyc"}, rx_cyc[0] - t0, 2 - HOFF);
            check({tag, "_last_cyc"}, rx_cyc[rx_cyc.size() - 1] - t0,
                  2 - HOFF + 2 * (exp_data.size() - 1));
        end
    endtask

    initial begin
        int t0;
        bit ok;
        int stall;

        rst_n             = 1'b0;
        halted            = 1'b0;
        dump_req          = 1'b0;
        pc                = 32'h0000_002B;
        dump_if.out_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) regfile[i] = DW'(3 * i);
        repeat (3) @(negedge clk1);

        check("rst_rf_addr", rf_addr, 0);
        check("rst_out_valid", dump_if.out_valid, 0);
        check("rst_out_data", dump_if.out_data, 0);
        check("rst_out_last", dump_if.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk1);

        // 1: regfile[i]=3i, ready always high, halted rising edge.
        dump_if.out_ready = 1'b1;
        clear_rx();
        fire(1'b1, 1'b0, t0);
        check("t1_busy", busy, 1'b1);
        wait_done("t1_done");
        check("t1_busy_end", busy, 1'b0);
        check("t1_valid_end", dump_if.out_valid, 1'b0);
        compare_dump("t1");
        check_timing("t1", t0);
        check("t1_last_word", (rx_data.size() > 0) ? rx_data[rx_data.size() - 1] : '0, 32'd93);
`ifdef MIPS32_DUMP_HDR_EN
        check("t6_header", (rx_data.size() > 0) ? rx_data[0] : '0, 32'hA520_002B);
`endif

        // 2: back-pressure on r2, register changes while it is being offered.
        for (int i = 0; i < NREGS; i++) regfile[i] = $urandom;
        regfile[2]        = 32'd232;
        regfile[3]        = 32'd3;
        dump_if.out_ready = 1'b0;
        clear_rx();
        fire(1'b0, 1'b1, t0);
        for (int w = 0; w < NREGS + HOFF; w++) begin
            wait_valid("t2_valid", ok);
            if (!ok) break;
            if (w == 2 + HOFF) begin
                repeat (5) begin
                    check("t2_stall_data", dump_if.out_data, 32'd232);
                    check("t2_stall_valid", dump_if.out_valid, 1'b1);
                    regfile[2] = $urandom;
                    @(negedge clk1);
                end
            end else begin
                stall = $urandom_range(0, 2);
                repeat (stall) @(negedge clk1);
            end
            dump_if.out_ready = 1'b1;
            @(negedge clk1);
            dump_if.out_ready = 1'b0;
        end
        wait_done("t2_done");
        compare_dump("t2");
        check("t2_word3", (rx_data.size() > 3 + HOFF) ? rx_data[3 + HOFF] : '0, 32'd3);

        // 3: halted is still high -- no new dump; ready high while idle does nothing.
        dump_if.out_ready = 1'b1;
        clear_rx();
        repeat (200) @(negedge clk1);
        check("t3_no_redump", rx_data.size(), 0);
        check("t3_done_held", done, 1'b1);
        check("t3_busy_low", busy, 1'b0);
        fire(1'b0, 1'b1, t0);
        wait_done("t3_done");
        compare_dump("t3");
        check_timing("t3", t0);

        // 4: reset in the middle of a dump, then a fresh halt edge restarts at r0.
        clear_rx();
        fire(1'b0, 1'b1, t0);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (rf_addr === AW'(10) && dump_if.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk1);
        end
        check("t4_reach_idx10", 64'(ok), 64'd1);
        rst_n  = 1'b0;
        halted = 1'b0;
        #1;
        check("t4_rst_valid", dump_if.out_valid, 1'b0);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_done", done, 1'b0);
        check("t4_rst_last", dump_if.out_last, 1'b0);
        check("t4_rst_addr", rf_addr, 0);
        @(negedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        clear_rx();
        repeat (5) @(negedge clk1);
        check("t4_idle_quiet", rx_data.size(), 0);
        check("t4_idle_busy", busy, 1'b0);
        fire(1'b1, 1'b0, t0);
        wait_done("t4_done");
        compare_dump("t4");
        check_timing("t4", t0);

        // 5: halted edge and dump_req together make one dump; dump_req mid-dump ignored.
        halted = 1'b0;
        repeat (3) @(negedge clk1);
        for (int i = 0; i < NREGS; i++) regfile[i] = $urandom;
        clear_rx();
        fire(1'b1, 1'b1, t0);
        repeat (10) @(negedge clk1);
        check("t5_busy_mid", busy, 1'b1);
        dump_req = 1'b1;
        @(negedge clk1);
        dump_req = 1'b0;
        wait_done("t5_done");
        compare_dump("t5");
        check_timing("t5", t0);
        repeat (10) @(negedge clk1);
        check("t5_no_extra", rx_data.size(), NREGS + HOFF);

        // Random contents, random PC and random back-pressure.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NREGS; i++) regfile[i] = $urandom;
            pc = $urandom;
            clear_rx();
            fire(1'b0, 1'b1, t0);
            for (int i = 0; i < 3000; i++) begin
                if (done === 1'b1) break;
                dump_if.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk1);
            end
            check($sformatf("rnd%0d_done", k), done, 1'b1);
            compare_dump($sformatf("rnd%0d", k));
        end

        dump_if.out_ready = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips32_reg_dump.md
Name: mips32_reg_dump

Overview:
- Post-run register-file readout engine for the mips32 pipelined core.
- The core's result path is the register file; this block reads it back once the core halts.
- It walks r0..r(NREGS-1) through a read port and streams each word out on a valid/ready interface for a host, scoreboard or UART bridge.
- It lets self-checking programs report results in hardware instead of through hierarchical peeks.

Parameters:
- NREGS, 32: number of registers dumped, r0..r(NREGS-1); must be ≥2.
- AW, 5: register address width; 2^AW ≥ NREGS.
- DW, 32: register and output data width.

Ports:
- clk1, input, 1: single clock; the core's phase-1 clock.
- rst_n, input, 1: asynchronous active-low reset.
- halted, input, 1: core halted flag; a rising edge triggers a dump.
- dump_req, input, 1: one-cycle manual dump trigger.
- pc, input, 32: core PC; used only by the optional header.
- rf_addr, output, AW: register-file read address.
- rf_rdata, input, DW: register-file read data; combinational from rf_addr.
- out_valid, output, 1: output word valid.
- out_ready, input, 1: consumer ready.
- out_data, output, DW: output word.
- out_last, output, 1: marks the final word of the dump.
- busy, output, 1: high while a dump is in progress.
- done, output, 1: dump complete; held until re-armed.

Behaviour:
- Reset (async, rst_n=0), all outputs 0:
  - rf_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - State IDLE, idx=0, halted_q=0.
  - Reset mid-dump aborts immediately; no partial word is held.
- Trigger:
  - trig = (halted & ~halted_q) | dump_req, where halted_q is halted registered every cycle.
  - halted held high produces exactly one dump.
  - halted edge and dump_req in the same cycle produce one dump.
  - trig is ignored unless the state is IDLE or DONE.
- States:
  - IDLE: busy=0. On trig: idx←0, rf_addr←0, busy←1, done←0, go to RD.
  - RD: rf_addr=idx is already registered. Next edge: out_data←rf_rdata, out_valid←1, out_last←(idx==NREGS-1), go to SEND.
  - SEND: out_valid stays high; out_data and out_last stay stable until out_valid & out_ready. On handshake:
    - Not last: out_valid←0, idx←idx+1, rf_addr←idx+1, go to RD.
    - Last: out_valid←0, out_last←0, busy←0, done←1, go to DONE.
  - DONE: done=1. On trig: start a new dump exactly as from IDLE.
- Timing:
  - First out_valid rises 2 edges after trig is sampled.
  - With out_ready held high, one word every 2 cycles.
  - A full dump takes 2·NREGS cycles after trig.
- Data rules:
  - rf_rdata is sampled at the RD→SEND edge only.
  - Register changes during SEND do not alter out_data.
- Address sequence:
  - idx and rf_addr increment by 1 with no wrap inside a dump.
  - idx returns to 0 only on a new trig.
- out_ready high while out_valid=0 has no effect.

Optional Feature:
- Macro: MIPS32_DUMP_HDR_EN.
- Defined:
  - On trig, the block enters state HDR instead of RD.
  - out_data←{8'hA5, 8'(NREGS), pc[15:0]} with pc sampled at trig; out_valid←1, out_last=0.
  - On the header handshake: rf_addr←0, go to RD.
  - Dump length is NREGS+1 words; first out_valid occurs 1 edge after trig.
- Undefined: no HDR state and no header word; pc is unused.

Test Plan:
1. regfile[i]=3·i, out_ready=1, pulse halted → 32 words 0,3,…,93 at 2-cycle spacing; out_last only on 93; then done=1, busy=0.
2. regfile[2]=232, regfile[3]=3; hold out_ready=0 for 5 cycles during word 2 → out_data=232 stays stable; after ready, word 3=3 follows.
3. halted held high 200 cycles after one dump → no second dump. dump_req pulse in DONE → a second identical 32-word dump.
4. Deassert rst_n while SEND at idx=10 → out_valid=0, busy=0, done=0 immediately. After release, halted rise → dump restarts at r0.
5. Halted rising edge and dump_req in the same cycle → exactly 32 words. dump_req while busy → ignored; word count stays 32.
6. MIPS32_DUMP_HDR_EN defined, pc=0x2B → first word 0xA520002B, then 32 register words; 33 total with out_last on the 33rd.
